iob_reset_seq: RTL



---
 rtl/iob_reset_seq_pkg.sv | 23 ++
 rtl/iob_sync.sv | 29 ++
 rtl/iob_reset_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/iob_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_reset_seq_pkg
// Brief    : State encoding and helpers shared by the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package iob_reset_seq_pkg;

    localparam int unsigned c_STATE_W = 2;

    // Encoding 3 is unused and is decoded as HOLD by the sequencer.
    typedef enum logic [c_STATE_W-1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_sync.sv
`default_nettype none
// ============================================================================
// Module   : iob_sync
// Brief    : Multi-flop synchroniser with asynchronous clear to 0.
// Revision : 1.0 - initial release
// ============================================================================
module iob_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/iob_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : iob_reset_seq
// Brief    : Power-on reset sequencer with lock qualification, hold count and
//            staggered per-channel release (channel 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module iob_reset_seq
    import iob_reset_seq_pkg::*;
#(
    parameter int unsigned N_RST       = 2,
    parameter int unsigned HOLD_CYCLES = 65535,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_EN     = 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 pll_lock_i,
    input  logic                 soft_rst_i,
    output logic [N_RST-1:0]     rst_o,
    output logic                 ready_o,
    output logic [c_STATE_W-1:0] state_o
);

    localparam int unsigned c_CNT_W = $clog2(max_u(HOLD_CYCLES, STAGGER)) + 1;
    localparam int unsigned c_IDX_W = $clog2(N_RST) + 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAGGER_LAST = c_CNT_W'(STAGGER - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(N_RST - 1);

    logic               w_sync_lock;
    logic               w_lock_s;
    logic               w_rearm;
    logic [N_RST-1:0]   r_rst;
    logic               r_ready;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;

    iob_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (arst_i),
        .i_d (pll_lock_i),
        .o_q (w_sync_lock)
    );

    assign w_lock_s = (LOCK_EN != 0) ? w_sync_lock : 1'b1;
    // Soft reset only re-arms once release has begun; in HOLD it just parks the count.
    assign w_rearm  = !w_lock_s ||
                      (soft_rst_i && ((r_state == ST_RELEASE) || (r_state == ST_RUN)));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (w_rearm) begin
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_RELEASE: begin
                    if (r_cnt == c_STAGGER_LAST) begin
                        // Channels release in index order, so a left shift clears bit r_idx.
                        r_rst <= r_rst << 1;
                        r_cnt <= '0;
                        r_idx <= r_idx + c_IDX_W'(1);
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    r_rst   <= '0;
                    r_ready <= 1'b1;
                end
                default: begin
                    if (soft_rst_i) begin
                        r_rst   <= '1;
                        r_ready <= 1'b0;
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_rst <= {N_RST{1'b1}} << 1;
                        r_cnt <= '0;
                        r_idx <= c_IDX_W'(1);
                        if (N_RST == 1) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_rst   <= '1;
                        r_ready <= 1'b0;
                        r_state <= ST_HOLD;
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rst_o   = r_rst;
    assign ready_o = r_ready;
    assign state_o = r_state;

endmodule
`default_nettype wire
